// File: rtl/afu_pll_ctrl_pkg.sv
// Shared types for the AFU PLL lock supervisor: FSM state encoding and sizing helpers.
package afu_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_ctrl_state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/afu_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module afu_sync2 (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/afu_pll_ctrl.sv
// PLL lock supervisor: pulses PLL reset, waits for lock with bounded retries,
// qualifies lock stability, then releases the AFU reset; re-sequences on loss or request.
module afu_pll_ctrl
  import afu_pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                               clk,
  input  logic                               resetb,
  input  logic                               pll_locked,
  input  logic                               relock_req,
  output logic                               pll_rst,
  output logic                               afu_resetb,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [LOSS_CNT_W-1:0]              lock_loss_cnt
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int TIMER_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  pll_ctrl_state_t          state, state_nxt;
  logic [TIMER_W-1:0]       timer, timer_nxt;
  logic [RETRY_W-1:0]       retry_nxt;
  logic [LOSS_CNT_W-1:0]    loss_nxt;
  logic                     lock_s;

  afu_sync2 u_lock_sync (
    .clk    (clk),
    .resetb (resetb),
    .d      (pll_locked),
    .q      (lock_s)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state         <= ST_RESET_PLL;
      timer         <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      afu_resetb    <= 1'b0;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      retry_cnt     <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
      // Outputs are decoded from the next state so they move on the transition edge.
      pll_rst       <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAIL);
      afu_resetb    <= (state_nxt == ST_RUN);
      ready         <= (state_nxt == ST_RUN);
      fail          <= (state_nxt == ST_FAIL);
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + TIMER_W'(1);
    retry_nxt = retry_cnt;
    loss_nxt  = lock_loss_cnt;
    unique case (state)
      ST_RESET_PLL: begin
        if (timer == RST_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = ST_STABILIZE;
        end else if (timer == TIMEOUT_LAST) begin
          if (retry_cnt == RETRY_MAX) begin
            state_nxt = ST_FAIL;
          end else begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            state_nxt = ST_RESET_PLL;
          end
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) state_nxt = ST_WAIT_LOCK;
        else if (timer == STABLE_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Lock loss takes priority over a coincident software request.
        if (!lock_s) begin
          if (lock_loss_cnt != '1) loss_nxt = lock_loss_cnt + LOSS_CNT_W'(1);
          retry_nxt = '0;
          state_nxt = ST_RESET_PLL;
        end else if (relock_req) begin
          retry_nxt = '0;
          state_nxt = ST_RESET_PLL;
        end
      end
      ST_FAIL: begin
        if (relock_req) begin
          retry_nxt = '0;
          state_nxt = ST_RESET_PLL;
        end
      end
      default: state_nxt = ST_RESET_PLL;
    endcase
    if (state_nxt != state) timer_nxt = '0;
  end

endmodule

// File: doc/afu_pll_ctrl.md
# afu_pll_ctrl

Lock supervisor and reset sequencer for the AFU engine PLL. Runs on the PLL reference clock. Sequences these steps:

- pulses the PLL reset;
- waits for `locked` with a timeout and a bounded number of retries;
- requires lock to be stable before releasing the downstream AFU reset;
- re-sequences on loss of lock or on software request.

It sits between the top-level reset and the PLL wrapper. Its reset output gates all engine-clock logic.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles the PLL reset is held high per attempt (≥2).
- `LOCK_TIMEOUT`, 4096: cycles allowed in WAIT_LOCK per attempt (≥2).
- `STABLE_CYCLES`, 256: consecutive synchronized-lock cycles required before release (≥1).
- `MAX_RETRIES`, 3: re-attempts after the first timeout before FAIL.

Ports:
- `clk` in 1: PLL reference clock; sole clock.
- `resetb` in 1: reset, asynchronous, active-low.
- `pll_locked` in 1: PLL lock, asynchronous to `clk`; synchronized internally.
- `relock_req` in 1: single-cycle software re-lock request.
- `pll_rst` out 1: drives the PLL `rst`, active-high.
- `afu_resetb` out 1: downstream AFU reset, active-low.
- `ready` out 1: high only in RUN.
- `fail` out 1: high only in FAIL.
- `retry_cnt` out `$clog2(MAX_RETRIES+1)`: timeouts in the current sequence.
- `lock_loss_cnt` out 8: lock drops seen in RUN, saturating at 255.

## Operation
- States: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL. One shared cycle `timer` is cleared on every state entry.
- **Reset values:**
  - state RESET_PLL, `timer` 0;
  - `pll_rst`=1, `afu_resetb`=0, `ready`=0, `fail`=0;
  - `retry_cnt`=0, `lock_loss_cnt`=0;
  - synchronizer flops 0.
- `lock_s` is `pll_locked` through two flops.
- **RESET_PLL:**
  - `pll_rst`=1.
  - When `timer`==`RST_CYCLES`-1, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - `pll_rst`=0.
  - If `lock_s`, go to STABILIZE.
  - Otherwise, when `timer`==`LOCK_TIMEOUT`-1:
    - if `retry_cnt`==`MAX_RETRIES`, go to FAIL;
    - otherwise increment `retry_cnt` and go to RESET_PLL.
- **STABILIZE:**
  - If `lock_s`=0, return to WAIT_LOCK with a fresh timeout and no retry increment.
  - When `timer`==`STABLE_CYCLES`-1 with `lock_s` high, go to RUN.
- **RUN:**
  - `afu_resetb`=1, `ready`=1.
  - If `lock_s`=0: increment `lock_loss_cnt` (saturating), clear `retry_cnt`, go to RESET_PLL.
  - Else if `relock_req`: clear `retry_cnt`, go to RESET_PLL. `lock_loss_cnt` is unchanged.
- **FAIL:**
  - `pll_rst`=1, `fail`=1.
  - On `relock_req`: clear `retry_cnt` and `fail`, go to RESET_PLL.
- `relock_req` is ignored in RESET_PLL, WAIT_LOCK and STABILIZE.
- `lock_loss_cnt` is cleared only by `resetb`.

## Timing
- All outputs are registered and change on the same edge as the state transition they belong to. `afu_resetb` drops on the edge that leaves RUN.
- Lock detection latency: 2 cycles synchronizer plus 1 cycle decision.
- With `pll_locked` constant 1 and default parameters, counting edge 1 as the first edge after `resetb` deasserts:
  - `pll_rst` falls at edge 16;
  - STABILIZE is entered at edge 17;
  - `afu_resetb` and `ready` rise at edge 273.
- Simultaneous lock loss and `relock_req` in RUN: lock loss wins, and the count increments.
- Asynchronous reset in any state returns to the reset values immediately, including `afu_resetb`=0.

## Structure
- Package `afu_pll_ctrl_pkg` holds the `pll_ctrl_state_t` enum and the state encoding.
- Sub-module `afu_sync2` is a 2-flop synchronizer with async active-low reset, used for `pll_locked`.
- Everything else lives in a single FSM with one timer and two counters.

## Test plan
- **Lock immediately:** `pll_locked`=1 from reset → `pll_rst` falls at edge 16, `afu_resetb`/`ready` rise at edge 273, `retry_cnt`=0.
- **Never lock** (`LOCK_TIMEOUT`=32): → 4 reset pulses, `retry_cnt` reaches 3, then `fail`=1 and `pll_rst`=1 held. Then `relock_req` → `fail`=0, `retry_cnt`=0, new pulse.
- **Glitch during STABILIZE:** drop lock for 1 cycle at timer 100 → back to WAIT_LOCK, release occurs a full `STABLE_CYCLES` after lock returns, `retry_cnt` unchanged.
- **Lock loss in RUN:** → `afu_resetb` low on the same edge the FSM leaves RUN, `lock_loss_cnt`=1, automatic re-sequence to RUN. After 256 such losses the count stays at 255.
- **Same-cycle relock and lock drop in RUN:** `relock_req` with lock high → re-sequence, `lock_loss_cnt` unchanged. `relock_req` coincident with lock drop → `lock_loss_cnt` increments.
- **Async reset mid-STABILIZE:** assert `resetb` → all outputs return to reset values without waiting for a clock edge.
